// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution output path.
// Provides output-size/address-width derivation and a saturating clamp.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DRAIN
    } coll_state_t;

    function automatic int out_size(
        input int fm,
        input int k,
        input int pad,
        input int stride
    );
        return (fm - k + 2 * pad) / stride + 1;
    endfunction

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clamp a signed value into the range of a signed 'width'-bit word.
    function automatic logic signed [63:0] sat_trunc(
        input logic signed [63:0] value,
        input int                 width
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

    // Defaults shared with the PE and the top level.
    localparam int DEF_KERNEL_SIZE = 3;
    localparam int DEF_FM_SIZE     = 8;
    localparam int DEF_PADDING     = 0;
    localparam int DEF_STRIDE      = 1;
    localparam int DEF_OUT_SIZE    = out_size(DEF_FM_SIZE, DEF_KERNEL_SIZE,
                                              DEF_PADDING, DEF_STRIDE);
    localparam int DEF_N_OUT       = DEF_OUT_SIZE * DEF_OUT_SIZE;
    localparam int DEF_ADDR_W      = addr_w(DEF_N_OUT);

endpackage

// File: rtl/conv_requant.sv
// Combinational requantiser: optional ReLU, round-half-up shift, saturate.
// Ports: i_sum (49-bit signed biased sum) -> o_q (OUT_W-bit signed result).
module conv_requant
    import conv_pkg::*;
#(
    parameter int OUT_W = 16,
    parameter int SHIFT = 8,
    parameter int RELU  = 1
) (
    input  logic signed [48:0]      i_sum,
    output logic signed [OUT_W-1:0] o_q
);

    // Half an LSB of the shifted result; zero when SHIFT is 0.
    localparam logic signed [63:0] RND = (64'sd1 <<< SHIFT) >>> 1;

    logic signed [63:0] w_relu;
    logic signed [63:0] w_shift;

    always_comb begin
        w_relu = 64'(i_sum);
        if (RELU != 0 && i_sum < 0) begin
            w_relu = '0;
        end
        w_shift = (w_relu + RND) >>> SHIFT;
        o_q     = OUT_W'(sat_trunc(w_shift, OUT_W));
    end

endmodule

// File: rtl/conv_out_collector.sv
// Collects the PE result stream, requantises it and writes the output map.
// Ports: i_start/i_en/i_P/i_bias in; o_addr/o_data/o_we/o_busy/o_done/o_err out.
module conv_out_collector
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int FM_SIZE     = 8,
    parameter int PADDING     = 0,
    parameter int STRIDE      = 1,
    parameter int OUT_W       = 16,
    parameter int SHIFT       = 8,
    parameter int RELU        = 1,
    localparam int OUT_SIZE   = out_size(FM_SIZE, KERNEL_SIZE,
                                         PADDING, STRIDE),
    localparam int N_OUT      = OUT_SIZE * OUT_SIZE,
    localparam int ADDR_W     = addr_w(N_OUT)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_en,
    input  logic signed [47:0]       i_P,
    input  logic signed [47:0]       i_bias,
    output logic        [ADDR_W-1:0] o_addr,
    output logic signed [OUT_W-1:0]  o_data,
    output logic                     o_we,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);

    coll_state_t r_state;
    coll_state_t w_state_n;
    logic        w_done_n;

    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_col;
    logic              r_err;
    logic              r_done;

    logic               r_v1;
    logic signed [48:0] r_s1;
    logic [ADDR_W-1:0]  r_a1;

    logic                    r_we;
    logic [ADDR_W-1:0]       r_addr;
    logic signed [OUT_W-1:0] r_data;

    logic                    w_acc;
    logic                    w_drop;
    logic                    w_last_col;
    logic                    w_last;
    logic [ADDR_W-1:0]       w_addr;
    logic signed [OUT_W-1:0] w_q;

    // A start in the same cycle always wins over a strobe.
    assign w_acc  = (r_state == ST_COLLECT) && i_en && !i_start;
    assign w_drop = (r_state != ST_COLLECT) && i_en && !i_start;

    assign w_last_col = (r_col == ADDR_W'(OUT_SIZE - 1));
    assign w_last     = w_last_col && (r_row == ADDR_W'(OUT_SIZE - 1));
    assign w_addr     = ADDR_W'(r_row * ADDR_W'(OUT_SIZE) + r_col);

    always_comb begin
        w_state_n = r_state;
        w_done_n  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_n = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (i_start) begin
                    w_state_n = ST_COLLECT;
                end else if (w_acc && w_last) begin
                    w_state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Stage 1 empty means the last write is on o_we now.
                if (i_start) begin
                    w_state_n = ST_COLLECT;
                end else if (!r_v1) begin
                    w_state_n = ST_IDLE;
                    w_done_n  = 1'b1;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    conv_requant #(
        .OUT_W (OUT_W),
        .SHIFT (SHIFT),
        .RELU  (RELU)
    ) u_requant (
        .i_sum (r_s1),
        .o_q   (w_q)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_err   <= 1'b0;
            r_v1    <= 1'b0;
            r_s1    <= '0;
            r_a1    <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_n;
            r_done  <= w_done_n;
            if (i_start) begin
                // Flush in-flight samples and rearm the counters.
                r_row <= '0;
                r_col <= '0;
                r_err <= 1'b0;
                r_v1  <= 1'b0;
                r_we  <= 1'b0;
            end else begin
                if (w_drop) begin
                    r_err <= 1'b1;
                end
                if (w_acc) begin
                    if (w_last_col) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                    r_s1 <= 49'(i_P) + 49'(i_bias);
                    r_a1 <= w_addr;
                end
                r_v1 <= w_acc;
                r_we <= r_v1;
                if (r_v1) begin
                    r_addr <= r_a1;
                    r_data <= w_q;
                end
            end
        end
    end

    assign o_addr = r_addr;
    assign o_data = r_data;
    assign o_we   = r_we;
    assign o_busy = (r_state != ST_IDLE);
    assign o_done = r_done;
    assign o_err  = r_err;

endmodule
